// File: rtl/rosco_pkg.sv
// Shared types and widths for the 68k bus-cycle termination logic.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package rosco_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        EXTW,
        ACK,
        BERR
    } bus_state_t;

    typedef enum logic [2:0] {
        RAM,
        ROM,
        IOEXP,
        CPUSP,
        NONE
    } region_t;

    localparam int WS_W                          = 4;
    localparam int BERR_CNT_W                    = 8;
    localparam logic [BERR_CNT_W-1:0] BERR_CNT_MAX = '1;

    // Fixed priority when the decoder asserts more than one select:
    // CPU space first, then RAM, ROM, IO/expansion; nothing selected is unmapped.
    function automatic region_t region_decode(
        input logic ramsel_n,
        input logic romsel_n,
        input logic iosel_n,
        input logic expsel_n,
        input logic cpusp
    );
        region_t r;
        if (cpusp)
            r = CPUSP;
        else if (!ramsel_n)
            r = RAM;
        else if (!romsel_n)
            r = ROM;
        else if (!iosel_n || !expsel_n)
            r = IOEXP;
        else
            r = NONE;
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level signal.
// Latency: 2 clocks from input change to q.
// Backpressure: none; reset value 1 (idle level of the active-low strobes).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two stages; reset forces the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_cycle_controller.sv
// 68k bus termination: wait-state DTACK for RAM/ROM, external DTACK pass-through, BERR watchdog.
// Latency: DTACK low N+1 clocks after the start clock (start clock is 2 clocks after AS is sampled).
// Backpressure: cycle held by the CPU via AS; terminations release only once AS is seen high.
module bus_cycle_controller
    import rosco_pkg::*;
#(
    parameter int RAM_WS               = 0,
    parameter int ROM_WS               = 2,
    parameter int TIMEOUT_CYCLES       = 1024,
    parameter int CPUSP_TIMEOUT_CYCLES = 64
) (
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic       i_AS_n,
    input  logic       i_RAMSEL_n,
    input  logic       i_ROMSEL_n,
    input  logic       i_IOSEL_n,
    input  logic       i_EXPSEL_n,
    input  logic       i_CPUSP,
    input  logic       i_EXT_DTACK_n,
    output logic       o_DTACK_n,
    output logic       o_BERR_n,
    output logic       o_TIMEOUT,
    output logic [7:0] o_BERR_COUNT
);

    localparam int TO_MAX = (TIMEOUT_CYCLES > CPUSP_TIMEOUT_CYCLES) ?
                            TIMEOUT_CYCLES : CPUSP_TIMEOUT_CYCLES;
    localparam int TO_W   = $clog2(TO_MAX) + 1;

    // The watchdog compares against limit-1: that is the last counted clock
    // before the FSM commits to BERR on the following edge.
    localparam logic [TO_W-1:0] TO_LAST_MEM = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST_CPU = TO_W'(CPUSP_TIMEOUT_CYCLES - 1);
    localparam logic [WS_W-1:0] RAM_WS_V    = WS_W'(RAM_WS);
    localparam logic [WS_W-1:0] ROM_WS_V    = WS_W'(ROM_WS);

    logic                  as_s;
    logic                  edt_s;
    logic                  as_prev;
    bus_state_t            state;
    bus_state_t            next_state;
    region_t               start_region;
    region_t               region_q;
    logic [WS_W-1:0]       wait_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [TO_W-1:0]       to_last;
    logic                  cycle_start;
    logic                  to_hit;
    logic                  berr_entry;
    logic                  dtack_n_q;
    logic                  berr_n_q;
    logic                  timeout_q;
    logic [BERR_CNT_W-1:0] berr_count_q;

    sync_2ff u_as_sync (
        .clk   (i_CLK),
        .rst_n (i_RST_n),
        .d     (i_AS_n),
        .q     (as_s)
    );

    sync_2ff u_edt_sync (
        .clk   (i_CLK),
        .rst_n (i_RST_n),
        .d     (i_EXT_DTACK_n),
        .q     (edt_s)
    );

    // Selects are combinational on the address, so they are settled well
    // before the synchronised AS edge that qualifies them.
    assign start_region = region_decode(i_RAMSEL_n, i_ROMSEL_n, i_IOSEL_n,
                                        i_EXPSEL_n, i_CPUSP);

    // Falling edge of synchronised AS, only honoured in IDLE so a held AS
    // after termination can never re-trigger.
    assign cycle_start = (state == IDLE) && !as_s && as_prev;
    assign to_hit      = (to_cnt == to_last);
    assign berr_entry  = ((state == WAIT) || (state == EXTW)) && (next_state == BERR);

    // FSM state register.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state decode; AS deassertion (abort) beats everything, ACK beats timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cycle_start) begin
                    if ((start_region == RAM) || (start_region == ROM))
                        next_state = WAIT;
                    else
                        next_state = EXTW;
                end
            end
            WAIT: begin
                if (as_s)
                    next_state = IDLE;
                else if (wait_cnt == '0)
                    next_state = ACK;
                else if (to_hit)
                    next_state = BERR;
            end
            EXTW: begin
                // Unmapped cycles ignore external DTACK and can only time out.
                if (as_s)
                    next_state = IDLE;
                else if (!edt_s && (region_q != NONE))
                    next_state = ACK;
                else if (to_hit)
                    next_state = BERR;
            end
            ACK, BERR: begin
                if (as_s)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Edge-detect history, per-cycle region/limit latch, wait and watchdog counters.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            as_prev  <= 1'b1;
            region_q <= NONE;
            wait_cnt <= '0;
            to_cnt   <= '0;
            to_last  <= '0;
        end else begin
            as_prev <= as_s;
            if (cycle_start) begin
                region_q <= start_region;
                to_cnt   <= '0;
                to_last  <= (start_region == CPUSP) ? TO_LAST_CPU : TO_LAST_MEM;
                wait_cnt <= (start_region == ROM) ? ROM_WS_V : RAM_WS_V;
            end else if ((state == WAIT) || (state == EXTW)) begin
                if (!to_hit)
                    to_cnt <= to_cnt + TO_W'(1);
                if ((state == WAIT) && (wait_cnt != '0))
                    wait_cnt <= wait_cnt - WS_W'(1);
            end else if (state == IDLE) begin
                to_cnt <= '0;
            end
        end
    end

    // Registered pin drivers decoded from the state being entered, so DTACK
    // and BERR can never be low together; bus-error pulse and saturating count.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            dtack_n_q    <= 1'b1;
            berr_n_q     <= 1'b1;
            timeout_q    <= 1'b0;
            berr_count_q <= '0;
        end else begin
            dtack_n_q <= (next_state != ACK);
            berr_n_q  <= (next_state != BERR);
            timeout_q <= berr_entry;
            if (berr_entry && (berr_count_q != BERR_CNT_MAX))
                berr_count_q <= berr_count_q + BERR_CNT_W'(1);
        end
    end

    assign o_DTACK_n    = dtack_n_q;
    assign o_BERR_n     = berr_n_q;
    assign o_TIMEOUT    = timeout_q;
    assign o_BERR_COUNT = berr_count_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Self-checking bench for bus_cycle_controller with default parameters.
// Latency references: clock 0 is the first rising edge after an input is driven.
// Backpressure: n/a.
module tb_bus_cycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       as_n = 1'b1;
    logic       ramsel_n = 1'b1;
    logic       romsel_n = 1'b1;
    logic       iosel_n = 1'b1;
    logic       expsel_n = 1'b1;
    logic       cpusp = 1'b0;
    logic       ext_dtack_n = 1'b1;
    logic       dtack_n;
    logic       berr_n;
    logic       timeout;
    logic [7:0] berr_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int to_pulses = 0;
    int exp_count = 0;

    typedef struct {
        bit is_berr;
        int at;
    } exp_t;

    exp_t sb[$];

    // select sets, bit order {cpusp, exp, io, rom, ram}, active high here
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_RAM  = 5'b00001;
    localparam logic [4:0] S_ROM  = 5'b00010;
    localparam logic [4:0] S_IO   = 5'b00100;
    localparam logic [4:0] S_CPU  = 5'b10000;

    bus_cycle_controller dut (
        .i_CLK         (clk),
        .i_RST_n       (rst_n),
        .i_AS_n        (as_n),
        .i_RAMSEL_n    (ramsel_n),
        .i_ROMSEL_n    (romsel_n),
        .i_IOSEL_n     (iosel_n),
        .i_EXPSEL_n    (expsel_n),
        .i_CPUSP       (cpusp),
        .i_EXT_DTACK_n (ext_dtack_n),
        .o_DTACK_n     (dtack_n),
        .o_BERR_n      (berr_n),
        .o_TIMEOUT     (timeout),
        .o_BERR_COUNT  (berr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (timeout === 1'b1) to_pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    task automatic bus_idle;
        ramsel_n    = 1'b1;
        romsel_n    = 1'b1;
        iosel_n     = 1'b1;
        expsel_n    = 1'b1;
        cpusp       = 1'b0;
        ext_dtack_n = 1'b1;
    endtask

    task automatic start_cycle(input logic [4:0] sel, output int t0);
        @(negedge clk);
        ramsel_n = ~sel[0];
        romsel_n = ~sel[1];
        iosel_n  = ~sel[2];
        expsel_n = ~sel[3];
        cpusp    = sel[4];
        as_n     = 1'b0;
        t0       = cyc + 1;
    endtask

    task automatic end_cycle(output int r0);
        @(negedge clk);
        as_n = 1'b1;
        r0   = cyc + 1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_term(input int budget, output int at, output bit is_berr);
        at = -1;
        is_berr = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dtack_n === 1'b0 || berr_n === 1'b0) begin
                at = cyc;
                is_berr = (berr_n === 1'b0);
                return;
            end
        end
    endtask

    task automatic wait_release(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dtack_n === 1'b1 && berr_n === 1'b1) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        as_n  = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack: got %b want 1", dtack_n); end
        checks++;
        if (berr_n !== 1'b1) begin errors++; $display("FAIL reset_berr: got %b want 1", berr_n); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++;
        if (berr_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", berr_count); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ram;
        int t0, r0, at;
        bit isb;
        exp_t e;
        start_cycle(S_RAM, t0);
        sb.push_back('{is_berr: 1'b0, at: t0 + 3});
        wait_term(40, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at || isb !== e.is_berr) begin
            errors++; $display("FAIL ram_dtack: got cycle %0d berr %0b want cycle %0d berr %0b", at, isb, e.at, e.is_berr);
        end
        end_cycle(r0);
        wait_release(40, at);
        // two synchroniser stages, then the registered exit from ACK
        checks++;
        if (at !== r0 + 2) begin errors++; $display("FAIL ram_release: got cycle %0d want %0d", at, r0 + 2); end
        bus_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rom;
        int t0, r0, at, p0;
        bit isb;
        exp_t e;
        p0 = to_pulses;
        start_cycle(S_ROM, t0);
        sb.push_back('{is_berr: 1'b0, at: t0 + 5});
        wait_term(40, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at || isb !== e.is_berr) begin
            errors++; $display("FAIL rom_dtack: got cycle %0d berr %0b want cycle %0d berr %0b", at, isb, e.at, e.is_berr);
        end
        end_cycle(r0);
        wait_release(40, at);
        checks++;
        if (to_pulses !== p0) begin errors++; $display("FAIL rom_no_timeout: got %0d pulses want %0d", to_pulses, p0); end
        bus_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_io;
        int t0, r0, at;
        bit isb;
        exp_t e;
        start_cycle(S_IO, t0);
        wait_until(t0 + 9);
        ext_dtack_n = 1'b0;
        sb.push_back('{is_berr: 1'b0, at: t0 + 12});
        wait_term(40, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at || isb !== e.is_berr) begin
            errors++; $display("FAIL io_dtack: got cycle %0d berr %0b want cycle %0d berr %0b", at, isb, e.at, e.is_berr);
        end
        end_cycle(r0);
        wait_release(40, at);
        bus_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unmapped;
        int t0, r0, at, p0;
        bit isb;
        exp_t e;
        p0 = to_pulses;
        start_cycle(S_NONE, t0);
        sb.push_back('{is_berr: 1'b1, at: t0 + 1026});
        wait_term(1100, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at || isb !== e.is_berr) begin
            errors++; $display("FAIL unmapped_berr: got cycle %0d berr %0b want cycle %0d berr %0b", at, isb, e.at, e.is_berr);
        end
        checks++;
        if (dtack_n !== 1'b1) begin errors++; $display("FAIL unmapped_no_dtack: got %b want 1", dtack_n); end
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL unmapped_pulse_on: got %b want 1", timeout); end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL unmapped_pulse_off: got %b want 0", timeout); end
        exp_count++;
        checks++;
        if (berr_count !== 8'(exp_count)) begin errors++; $display("FAIL unmapped_count: got %0d want %0d", berr_count, exp_count); end
        end_cycle(r0);
        wait_release(40, at);
        checks++;
        if (at !== r0 + 2) begin errors++; $display("FAIL unmapped_release: got cycle %0d want %0d", at, r0 + 2); end
        checks++;
        if (to_pulses !== p0 + 1) begin errors++; $display("FAIL unmapped_pulses: got %0d want %0d", to_pulses - p0, 1); end
        bus_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpusp;
        int t0, r0, at, p0;
        bit isb;
        exp_t e;
        // no responder: short CPU-space watchdog
        start_cycle(S_CPU, t0);
        sb.push_back('{is_berr: 1'b1, at: t0 + 66});
        wait_term(200, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at || isb !== e.is_berr) begin
            errors++; $display("FAIL cpusp_berr: got cycle %0d berr %0b want cycle %0d berr %0b", at, isb, e.at, e.is_berr);
        end
        exp_count++;
        end_cycle(r0);
        wait_release(40, at);
        bus_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (berr_count !== 8'(exp_count)) begin errors++; $display("FAIL cpusp_count: got %0d want %0d", berr_count, exp_count); end
        // responder lands on the very clock the watchdog expires: ACK wins
        p0 = to_pulses;
        start_cycle(S_CPU, t0);
        wait_until(t0 + 63);
        ext_dtack_n = 1'b0;
        sb.push_back('{is_berr: 1'b0, at: t0 + 66});
        wait_term(200, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at || isb !== e.is_berr) begin
            errors++; $display("FAIL cpusp_race: got cycle %0d berr %0b want cycle %0d berr %0b", at, isb, e.at, e.is_berr);
        end
        end_cycle(r0);
        wait_release(40, at);
        bus_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (berr_count !== 8'(exp_count)) begin errors++; $display("FAIL cpusp_race_count: got %0d want %0d", berr_count, exp_count); end
        checks++;
        if (to_pulses !== p0) begin errors++; $display("FAIL cpusp_race_pulse: got %0d pulses want 0", to_pulses - p0); end
    endtask

    task automatic test_priority;
        logic [4:0] sels [3] = '{S_RAM | S_ROM, S_CPU | S_RAM, S_ROM | S_IO | 5'b01000};
        int         lat  [3] = '{3, 66, 5};
        bit         brr  [3] = '{1'b0, 1'b1, 1'b0};
        int t0, r0, at;
        bit isb;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            start_cycle(sels[k], t0);
            sb.push_back('{is_berr: brr[k], at: t0 + lat[k]});
            if (brr[k]) exp_count++;
            wait_term(200, at, isb);
            e = sb.pop_front();
            checks++;
            if (at !== e.at || isb !== e.is_berr) begin
                errors++; $display("FAIL priority_%0d: got cycle %0d berr %0b want cycle %0d berr %0b", k, at, isb, e.at, e.is_berr);
            end
            end_cycle(r0);
            wait_release(40, at);
            bus_idle();
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_abort;
        int t0, r0, at;
        bit isb;
        exp_t e;
        start_cycle(S_IO, t0);
        wait_until(t0 + 10);
        end_cycle(r0);
        sb.push_back('{is_berr: 1'b0, at: -1});
        wait_term(40, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at) begin errors++; $display("FAIL abort_silent: got termination at cycle %0d want none", at); end
        checks++;
        if (berr_count !== 8'(exp_count)) begin errors++; $display("FAIL abort_count: got %0d want %0d", berr_count, exp_count); end
        bus_idle();
    endtask

    task automatic test_back_to_back;
        logic [4:0] sels [3] = '{S_RAM, S_ROM, S_RAM};
        int         lat  [3] = '{3, 5, 3};
        int t0, r0, at;
        bit isb;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            start_cycle(sels[k], t0);
            sb.push_back('{is_berr: 1'b0, at: t0 + lat[k]});
            wait_term(40, at, isb);
            e = sb.pop_front();
            checks++;
            if (at !== e.at || isb !== e.is_berr) begin
                errors++; $display("FAIL b2b_%0d: got cycle %0d berr %0b want cycle %0d berr %0b", k, at, isb, e.at, e.is_berr);
            end
            end_cycle(r0);
            wait_release(40, at);
        end
        bus_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int t0, r0, at;
        bit isb;
        exp_t e;
        start_cycle(S_NONE, t0);
        wait_until(t0 + 20);
        rst_n = 1'b0;
        @(negedge clk);
        exp_count = 0;
        checks++;
        if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin
            errors++; $display("FAIL midreset_pins: got dtack %b berr %b want 1 1", dtack_n, berr_n);
        end
        checks++;
        if (berr_count !== 8'(exp_count)) begin errors++; $display("FAIL midreset_count: got %0d want 0", berr_count); end
        as_n = 1'b1;
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        start_cycle(S_RAM, t0);
        sb.push_back('{is_berr: 1'b0, at: t0 + 3});
        wait_term(40, at, isb);
        e = sb.pop_front();
        checks++;
        if (at !== e.at || isb !== e.is_berr) begin
            errors++; $display("FAIL midreset_ram: got cycle %0d berr %0b want cycle %0d berr %0b", at, isb, e.at, e.is_berr);
        end
        end_cycle(r0);
        wait_release(40, at);
        bus_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (berr_count !== 8'(exp_count)) begin errors++; $display("FAIL midreset_final_count: got %0d want 0", berr_count); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_rom();
        test_io();
        test_unmapped();
        test_cpusp();
        test_priority();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
